muldiv_unit: RTL

//   Iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/muldiv_unit_pkg.sv | 19 +
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit_core.sv | 62 ++++++
 rtl/muldiv_unit.sv | 97 +++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op and FSM state encodings for the multiply/divide unit
//   op_t    : MULT/MULTU/DIV/DIVU encodings, reused by the decoder and hazard unit
//   state_t : IDLE -> RUN -> FIX sequencing states
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the pipeline and the multiply/divide unit
//   master : drives start, op, src_a, src_b, mthi, mtlo, wdata; observes busy, done, hi, lo
//   slave  : the unit side of the same signals
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    op_t              op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_core.sv
// muldiv_core: WIDTH-step radix-2 datapath (shift-add multiply, restoring divide) on unsigned magnitudes
//   clk, reset : clock, async active-high reset
//   load_i     : capture operands a_i/b_i and clear the step counter
//   step_en_i  : perform one iteration this cycle
//   div_i      : 1 = divide, 0 = multiply (must be stable from load through the last step)
//   a_i, b_i   : multiplicand/dividend, multiplier/divisor magnitudes
//   last_o     : the current step is the final (WIDTH-th) one
//   hi_o, lo_o : product {hi,lo}, or remainder (hi) and quotient (lo)
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_en_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   sum, shifted, diff;

    // lo_q holds the multiplier (consumed from bit 0) or the dividend
    // (consumed from the top while quotient bits shift in at the bottom).
    always_comb begin
        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {acc_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        acc_d   = div_i ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        lo_d    = div_i ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
        end else if (load_i) begin
            count_q <= '0;
            acc_q   <= '0;
            lo_q    <= div_i ? a_i : b_i;
            opnd_q  <= div_i ? b_i : a_i;
        end else if (step_en_i) begin
            count_q <= count_q + 1'b1;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
        end
    end

    assign last_o = step_en_i && (count_q == CW'(WIDTH - 1));
    assign hi_o   = acc_q;
    assign lo_o   = lo_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers
//   clk, reset : clock, async active-high reset (discards any in-flight op)
//   bus        : slave side of muldiv_unit_if (start/op/src_a/src_b, mthi/mtlo/wdata in;
//                busy/done/hi/lo out)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    state_t             state_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               div_q, neg_res_q, neg_rem_q, divz_q;
    logic               load, step_en, last, core_div;
    logic               start_div, start_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, core_hi, core_lo, hi_res, lo_res;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign load         = (state_q == S_IDLE) && bus.start;
    assign step_en      = (state_q == S_RUN);
    assign start_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign start_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg        = start_signed && bus.src_a[WIDTH-1];
    assign b_neg        = start_signed && bus.src_b[WIDTH-1];
    assign a_mag        = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag        = b_neg ? -bus.src_b : bus.src_b;
    assign core_div     = load ? start_div : div_q;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .step_en_i (step_en),
        .div_i     (core_div),
        .a_i       (a_mag),
        .b_i       (b_mag),
        .last_o    (last),
        .hi_o      (core_hi),
        .lo_o      (core_lo)
    );

    // Divide by zero leaves the quotient at all-ones unsigned; its sign is not
    // corrected so LO stays all-ones, while the remainder naturally equals |a|
    // and the remainder sign fix restores the raw dividend.
    assign prod     = {core_hi, core_lo};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign hi_res   = div_q ? (neg_rem_q ? -core_hi : core_hi) : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_res   = div_q ? (divz_q ? '1 : neg_res_q ? -core_lo : core_lo) : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mthi) hi_q <= bus.wdata;
                    if (bus.mtlo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        div_q     <= start_div;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        divz_q    <= start_div && (bus.src_b == '0);
                    end
                end
                S_RUN: if (last) state_q <= S_FIX;
                S_FIX: begin
                    hi_q    <= hi_res;
                    lo_q    <= lo_res;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
